// File: rtl/seven_segment_capture.sv
`default_nettype none
// ==== seven_segment_capture : multiplexed 7-segment bus -> per-digit BCD frame capture ====
// ==== Revision 1.0 ========================================================================
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_valid
);

  localparam int         SAMPLE_W = NUM_DIGITS + 7;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_LOCK = 8'(STABLE_CYCLES);

  typedef enum logic [0:0] {
    UNSTABLE = 1'b0,
    LOCKED   = 1'b1
  } filt_state_t;

  filt_state_t             state;
  logic [SAMPLE_W-1:0]     s_reg;
  logic [7:0]              cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic [SAMPLE_W-1:0]     sample;
  logic                    sel_onehot;
  logic                    same;
  logic                    capture;
  logic                    mask_full;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   mask_next;

  // Returns {illegal_flag, nibble}; anything outside the ten digit glyphs is 4'hF + flag.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  always_comb begin
    sample     = {dig_sel, seg};
    sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    same       = (sample == s_reg);
    capture    = sel_onehot && same && (cnt == CNT_LAST);
    dec        = decode_seg(seg);
    mask_full  = &mask;
    // A capture landing on the publish edge seeds the next frame's mask.
    mask_next  = (mask_full ? '0 : mask) | (capture ? dig_sel : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg <= '0;
      cnt   <= '0;
      state <= UNSTABLE;
    end else begin
      s_reg <= sample;
      if (!same || !sel_onehot) begin
        cnt   <= '0;
        state <= UNSTABLE;
      end else if (cnt == CNT_LAST) begin
        cnt   <= CNT_LOCK;
        state <= LOCKED;
      end else if (state == UNSTABLE) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask        <= '0;
      shadow      <= '1;
      shadow_err  <= '0;
      bcd         <= '1;
      err         <= '0;
      frame_valid <= 1'b0;
    end else begin
      mask        <= mask_next;
      frame_valid <= mask_full;
      if (mask_full) begin
        bcd <= shadow;
        err <= shadow_err;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && dig_sel[i]) begin
          shadow[4*i +: 4] <= dec[3:0];
          shadow_err[i]    <= dec[4];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ==== tb_seven_segment_capture : randomized + directed bench with a behavioural frame model ====
module tb_seven_segment_capture;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] bcd;
  logic [3:0]  err;
  logic        frame_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_seen  = 0;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Model: run length of the current input value, plus per-digit shadow/have flags.
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_shadow [4];
  logic        m_shadow_err [4];
  logic        m_have [4];
  logic [15:0] m_bcd;
  logic [3:0]  m_err;
  logic        m_fv;

  seven_segment_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
    .bcd(bcd), .err(err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++)
      if (pat[k] == p) return {1'b0, 4'(k)};
    return 5'h1F;
  endfunction

  task automatic step(input logic [3:0] ds, input logic [6:0] sg, input logic r);
    logic [10:0] cur;
    logic [4:0]  d;
    @(negedge clk);
    dig_sel = ds; seg = sg; rst = r;
    @(posedge clk);
    cur = {ds, sg};
    if (r) begin
      m_prev = '0; m_run = 0; m_bcd = 16'hFFFF; m_err = '0; m_fv = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_shadow[k] = 4'hF; m_shadow_err[k] = 1'b0; m_have[k] = 1'b0;
      end
    end else begin
      m_run  = (cur == m_prev) ? m_run + 1 : 1;
      m_prev = cur;
      m_fv   = m_have[0] && m_have[1] && m_have[2] && m_have[3];
      if (m_fv) begin
        for (int k = 0; k < 4; k++) begin
          m_bcd[4*k +: 4] = m_shadow[k];
          m_err[k]        = m_shadow_err[k];
          m_have[k]       = 1'b0;
        end
      end
      if ($countones(ds) == 1 && m_run == SC + 1) begin
        d = ref_decode(sg);
        for (int k = 0; k < 4; k++)
          if (ds[k]) begin
            m_shadow[k] = d[3:0]; m_shadow_err[k] = d[4]; m_have[k] = 1'b1;
          end
      end
    end
    #1;
    if (frame_valid === 1'b1) fv_seen++;
  endtask

  task automatic hold(input logic [3:0] ds, input logic [6:0] sg, input int n);
    repeat (n) step(ds, sg, 1'b0);
  endtask

  task automatic test_reset;
    step(4'b0000, 7'b0, 1'b1);
    step(4'b0000, 7'b0, 1'b1);
    n_checks++; if (bcd !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bcd: got %h expected ffff", bcd); end
    n_checks++; if (err !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b expected 0000", err); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
    step(4'b0000, 7'b0, 1'b0);
  endtask

  task automatic test_scan_basic;
    int f0 = fv_seen;
    hold(4'b0001, pat[1], 6); hold(4'b0010, pat[2], 6);
    hold(4'b0100, pat[3], 6); hold(4'b1000, pat[4], 6);
    hold(4'b0000, 7'b0, 2);
    n_checks++; if (fv_seen - f0 != 1) begin n_fail++; $display("FAIL scan_fv_count: got %0d expected 1", fv_seen - f0); end
    n_checks++; if (bcd !== 16'h4321) begin n_fail++; $display("FAIL scan_bcd: got %h expected 4321", bcd); end
    n_checks++; if (err !== 4'b0000) begin n_fail++; $display("FAIL scan_err: got %b expected 0000", err); end
  endtask

  task automatic test_stable_boundary;
    int f0 = fv_seen;
    hold(4'b0001, pat[0], 4); hold(4'b0000, 7'b0, 3);
    hold(4'b0010, pat[5], 6); hold(4'b0100, pat[6], 6); hold(4'b1000, pat[7], 6);
    hold(4'b0000, 7'b0, 3);
    n_checks++; if (fv_seen != f0) begin n_fail++; $display("FAIL short_hold_captured: got %0d frames expected 0", fv_seen - f0); end
    hold(4'b0001, pat[0], 5);
    step(4'b0000, 7'b0, 1'b0);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL latency_fv: got %b expected 1", frame_valid); end
    n_checks++; if (bcd !== 16'h7650) begin n_fail++; $display("FAIL latency_bcd: got %h expected 7650", bcd); end
    step(4'b0000, 7'b0, 1'b0);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL fv_one_cycle: got %b expected 0", frame_valid); end
  endtask

  task automatic test_glitch;
    int f0 = fv_seen;
    hold(4'b0010, pat[8], 6); hold(4'b0100, pat[9], 6); hold(4'b1000, pat[1], 6);
    hold(4'b0001, pat[3], 3); hold(4'b0001, pat[8], 1); hold(4'b0001, pat[3], 4);
    step(4'b0000, 7'b0, 1'b0);
    n_checks++; if (fv_seen != f0) begin n_fail++; $display("FAIL glitch_no_restart: got %0d frames expected 0", fv_seen - f0); end
    hold(4'b0001, pat[3], 3); hold(4'b0001, pat[8], 1); hold(4'b0001, pat[3], 5);
    step(4'b0000, 7'b0, 1'b0);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_capture_fv: got %b expected 1", frame_valid); end
    n_checks++; if (bcd !== 16'h1983) begin n_fail++; $display("FAIL glitch_bcd: got %h expected 1983", bcd); end
  endtask

  task automatic test_bad_sel;
    int f0 = fv_seen;
    hold(4'b0000, pat[8], 20); hold(4'b0011, pat[8], 20);
    hold(4'b0100, 7'b1001001, 6); hold(4'b1000, pat[2], 6); hold(4'b0000, 7'b0, 2);
    n_checks++; if (fv_seen != f0) begin n_fail++; $display("FAIL bad_sel_mask: got %0d frames expected 0", fv_seen - f0); end
    hold(4'b0001, pat[0], 6); hold(4'b0010, pat[1], 6); hold(4'b0000, 7'b0, 2);
    n_checks++; if (bcd !== 16'h2F10) begin n_fail++; $display("FAIL illegal_bcd: got %h expected 2f10", bcd); end
    n_checks++; if (err !== 4'b0100) begin n_fail++; $display("FAIL illegal_err: got %b expected 0100", err); end
    hold(4'b0001, pat[5], 6); hold(4'b0010, pat[6], 6);
    hold(4'b0100, 7'b0000000, 6); hold(4'b1000, pat[9], 6); hold(4'b0000, 7'b0, 2);
    n_checks++; if ({err, bcd} !== {4'b0100, 16'h9F65}) begin n_fail++; $display("FAIL blank_digit: got %b/%h expected 0100/9f65", err, bcd); end
  endtask

  task automatic test_recapture;
    int f0 = fv_seen;
    hold(4'b0010, pat[5], 6); hold(4'b0001, pat[0], 6); hold(4'b0010, pat[7], 6);
    hold(4'b0100, pat[4], 6); hold(4'b1000, pat[3], 6); hold(4'b0000, 7'b0, 2);
    n_checks++; if (fv_seen - f0 != 1) begin n_fail++; $display("FAIL recapture_fv: got %0d expected 1", fv_seen - f0); end
    n_checks++; if (bcd !== 16'h3470) begin n_fail++; $display("FAIL recapture_bcd: got %h expected 3470", bcd); end
  endtask

  task automatic test_back_to_back;
    hold(4'b0001, pat[1], 5); hold(4'b0010, pat[2], 5);
    hold(4'b0100, pat[3], 5); hold(4'b1000, pat[4], 5);
    step(4'b0001, pat[9], 1'b0);
    n_checks++; if ({frame_valid, bcd} !== {1'b1, 16'h4321}) begin n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/4321", frame_valid, bcd); end
    hold(4'b0001, pat[9], 4); hold(4'b0010, pat[8], 5);
    hold(4'b0100, pat[7], 5); hold(4'b1000, pat[6], 5);
    step(4'b0000, 7'b0, 1'b0);
    n_checks++; if ({frame_valid, bcd} !== {1'b1, 16'h6789}) begin n_fail++; $display("FAIL b2b_second: got %b/%h expected 1/6789", frame_valid, bcd); end
  endtask

  task automatic test_reset_midframe;
    int f0;
    hold(4'b0001, pat[1], 6); hold(4'b0010, pat[2], 6);
    step(4'b0000, 7'b0, 1'b1);
    n_checks++; if ({frame_valid, err, bcd} !== {1'b0, 4'b0000, 16'hFFFF}) begin n_fail++; $display("FAIL midreset_state: got %b/%b/%h expected 0/0000/ffff", frame_valid, err, bcd); end
    f0 = fv_seen;
    step(4'b0000, 7'b0, 1'b0);
    hold(4'b0100, pat[3], 6); hold(4'b1000, pat[4], 6); hold(4'b0000, 7'b0, 3);
    n_checks++; if (fv_seen != f0 || bcd !== 16'hFFFF) begin n_fail++; $display("FAIL midreset_partial: got %0d frames bcd %h expected 0 frames ffff", fv_seen - f0, bcd); end
    hold(4'b0001, pat[5], 6); hold(4'b0010, pat[6], 6); hold(4'b0000, 7'b0, 2);
    n_checks++; if (fv_seen - f0 != 1 || bcd !== 16'h4365) begin n_fail++; $display("FAIL midreset_new_frame: got %0d frames bcd %h expected 1 frame 4365", fv_seen - f0, bcd); end
  endtask

  task automatic test_random;
    logic [3:0] ds;
    logic [6:0] sg;
    int         n;
    for (int s = 0; s < 300; s++) begin
      ds = ($urandom_range(9, 0) < 7) ? 4'(4'b0001 << $urandom_range(3, 0)) : 4'($urandom);
      sg = ($urandom_range(9, 0) < 7) ? pat[$urandom_range(9, 0)] : 7'($urandom);
      n  = $urandom_range(7, 1);
      for (int c = 0; c < n; c++) begin
        step(ds, sg, ($urandom_range(199, 0) == 0));
        n_checks++;
        if ({frame_valid, err, bcd} !== {m_fv, m_err, m_bcd}) begin
          n_fail++;
          $display("FAIL random_step%0d: got fv=%b err=%b bcd=%h expected fv=%b err=%b bcd=%h",
                   s, frame_valid, err, bcd, m_fv, m_err, m_bcd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_stable_boundary();
    test_glitch();
    test_bad_sel();
    test_recapture();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
